health_control: RTL

//  Per-fighter hit-point tracker for the battle stage. Consumes hit events from
//  the collision logic, applies damage with saturating arithmetic, enforces a

---
 rtl/health_control.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/health_control.sv
// Per-fighter hit-point tracker: edge-detected hits, saturating damage,
// post-hit invulnerability window and a timed death-hold pulse per fighter.

module health_channel #(
    parameter int MAX_HP        = 100,
    parameter int HP_W          = 7,
    parameter int DMG_W         = 6,
    parameter int INVULN_FRAMES = 30,
    parameter int DEATH_HOLD    = 60,
    parameter int CNT_W         = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_l,
    input  logic             battle_l,
    input  logic             hit,
    input  logic [DMG_W-1:0] dmg,
    output logic [HP_W-1:0]  hp,
    output logic             dead,
    output logic             flash,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {ALIVE, INVULN, DYING, DEAD} fighter_state_t;

    fighter_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HP_W-1:0]  hp_d;
    logic             hit_q;
    logic             hit_edge;
    logic             accept;

    // A hit is a level from collision logic; only its rising edge counts,
    // and only while the fighter is vulnerable during battle.
    assign hit_edge  = hit & ~hit_q;
    assign accept    = hit_edge & battle_l & ~start_l & (state_q == ALIVE) &
                       (dmg != '0);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp;
        case (state_q)
            ALIVE: begin
                if (accept) begin
                    if (HP_W'(dmg) >= hp) begin
                        state_d = DYING;
                        hp_d    = '0;
                        cnt_d   = CNT_W'(DEATH_HOLD - 1);
                    end else begin
                        hp_d = hp - HP_W'(dmg);
                        if (INVULN_FRAMES > 0) begin
                            state_d = INVULN;
                            cnt_d   = CNT_W'(INVULN_FRAMES - 1);
                        end
                    end
                end
            end
            INVULN: begin
                if (cnt_q == '0) state_d = ALIVE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DYING: begin
                if (cnt_q == '0) state_d = DEAD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DEAD: begin
                hp_d = '0;
            end
            default: begin
                state_d = ALIVE;
            end
        endcase
        // Reload wins over any in-flight hit or running count.
        if (start_l) begin
            state_d = ALIVE;
            cnt_d   = '0;
            hp_d    = HP_W'(MAX_HP);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ALIVE;
            cnt_q   <= '0;
            hp      <= HP_W'(MAX_HP);
            hit_q   <= 1'b0;
            dead    <= 1'b0;
            flash   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp      <= hp_d;
            hit_q   <= hit;
            dead    <= (state_d == DYING);
            flash   <= (state_d == INVULN);
        end
    end

endmodule

module health_control #(
    parameter int MAX_HP        = 100,
    parameter int HP_W          = 7,
    parameter int DMG_W         = 6,
    parameter int INVULN_FRAMES = 30,
    parameter int DEATH_HOLD    = 60,
    parameter int CNT_W         = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_l,
    input  logic             battle_l,
    input  logic             Player_Hit,
    input  logic [DMG_W-1:0] Player_Dmg,
    input  logic             NPC_Hit,
    input  logic [DMG_W-1:0] NPC_Dmg,
    output logic [HP_W-1:0]  Player_HP,
    output logic [HP_W-1:0]  NPC_HP,
    output logic             Player_Dead,
    output logic             NPC_Dead,
    output logic             Player_Flash,
    output logic             NPC_Flash,
    output logic [1:0]       Player_State,
    output logic [1:0]       NPC_State
);

    health_channel #(
        .MAX_HP(MAX_HP), .HP_W(HP_W), .DMG_W(DMG_W),
        .INVULN_FRAMES(INVULN_FRAMES), .DEATH_HOLD(DEATH_HOLD), .CNT_W(CNT_W)
    ) u_player (
        .Clk(Clk), .Reset(Reset), .start_l(start_l), .battle_l(battle_l),
        .hit(Player_Hit), .dmg(Player_Dmg), .hp(Player_HP),
        .dead(Player_Dead), .flash(Player_Flash), .state_dbg(Player_State)
    );

    health_channel #(
        .MAX_HP(MAX_HP), .HP_W(HP_W), .DMG_W(DMG_W),
        .INVULN_FRAMES(INVULN_FRAMES), .DEATH_HOLD(DEATH_HOLD), .CNT_W(CNT_W)
    ) u_npc (
        .Clk(Clk), .Reset(Reset), .start_l(start_l), .battle_l(battle_l),
        .hit(NPC_Hit), .dmg(NPC_Dmg), .hp(NPC_HP),
        .dead(NPC_Dead), .flash(NPC_Flash), .state_dbg(NPC_State)
    );

endmodule
